// File: rtl/slow_clk_mon.sv
// Slow-clock monitor: synchronises sig_in, emits edge strobes, measures half-periods and flags stalls.
// Optional rising-edge counter output enabled by defining SLOW_CLK_MON_EDGE_CNT_EN.
module slow_clk_mon #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned MIN_HALF    = 16_000_000,
  parameter int unsigned MAX_HALF    = 16_500_000
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] half_period,
  output logic             period_valid,
  output logic             in_range,
`ifdef SLOW_CLK_MON_EDGE_CNT_EN
  output logic             timeout,
  output logic [15:0]      edge_count
`else
  output logic             timeout
`endif
);

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_HALF);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_HALF);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  typedef enum logic [1:0] {INIT, MEAS, TMO} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q, fall_q;
  logic                   sync_out, edge_det, rise_det, fall_det;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [CNT_W-1:0]       half_q, half_d;
  logic                   pv_q, pv_d;
  logic                   inr_q, inr_d;
  logic                   to_q, to_d;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign edge_det = sync_out ^ prev_q;
  assign rise_det = sync_out & ~prev_q;
  assign fall_det = ~sync_out & prev_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      state_q <= INIT;
      count_q <= '0;
      half_q  <= '0;
      pv_q    <= 1'b0;
      inr_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q  <= sync_out;
      rise_q  <= rise_det;
      fall_q  <= fall_det;
      state_q <= state_d;
      count_q <= count_d;
      half_q  <= half_d;
      pv_q    <= pv_d;
      inr_q   <= inr_d;
      to_q    <= to_d;
    end
  end

  // An edge in the threshold cycle takes priority, so a MAX_HALF spacing is a valid measurement.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    half_d  = half_q;
    pv_d    = 1'b0;
    inr_d   = inr_q;
    to_d    = to_q;
    case (state_q)
      INIT: begin
        count_d = '0;
        if (edge_det) begin
          state_d = MEAS;
          count_d = ONE_C;
        end
      end
      MEAS: begin
        if (edge_det) begin
          half_d  = count_q;
          pv_d    = 1'b1;
          inr_d   = (count_q >= MIN_C) && (count_q <= MAX_C);
          count_d = ONE_C;
        end else if (count_q == MAX_C) begin
          state_d = TMO;
          to_d    = 1'b1;
          inr_d   = 1'b0;
        end else if (count_q != '1) begin
          count_d = count_q + ONE_C;
        end
      end
      TMO: begin
        if (edge_det) begin
          state_d = MEAS;
          to_d    = 1'b0;
          count_d = ONE_C;
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign half_period  = half_q;
  assign period_valid = pv_q;
  assign in_range     = inr_q;
  assign timeout      = to_q;

`ifdef SLOW_CLK_MON_EDGE_CNT_EN
  logic [15:0] ecnt_q;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)        ecnt_q <= '0;
    else if (rise_det) ecnt_q <= ecnt_q + 16'd1;
  end

  assign edge_count = ecnt_q;
`endif

endmodule
